// File: rtl/inj_sched_rr.sv
// Round-robin injection scheduler: grants each traffic ROM up to QUANTUM word requests, merges returns into one flit port.
// Latency: a flit is visible 1 cycle after capture; backpressure withholds src_enable once FIFO + in-flight reaches FDEPTH.
`timescale 1ns/1ps
module inj_sched_rr #(
    parameter int N_SRC     = 4,
    parameter int DW        = 20,
    parameter int BURST_LEN = 30,
    parameter int QUANTUM   = 4,
    parameter int GAP       = 1,
    parameter int FDEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [N_SRC-1:0]           src_enable,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*DW-1:0]        src_data,
    output logic [DW-1:0]              flit_out,
    output logic [$clog2(N_SRC)-1:0]   flit_src,
    output logic                       flit_valid,
    input  logic                       flit_ready,
    output logic                       busy,
    output logic                       all_done,
    output logic                       err_stray
);
    localparam int SW = $clog2(N_SRC);
    localparam int RW = $clog2(BURST_LEN + 1);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_STREAM, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      ptr, g, pick_idx, inflight_src, cap_idx;
    logic [QW-1:0]      qcnt;
    logic [GW-1:0]      gcnt;
    logic [RW-1:0]      rem     [N_SRC];
    logic [RW-1:0]      rem_req [N_SRC];
    logic [N_SRC-1:0]   act, expect_mask;
    logic               inflight, pick_found, can_req, activate, reload;
    logic               cap_vld, push, pop, stray_hit;
    logic [DW-1:0]      cap_dat;

    logic [SW+DW-1:0]   mem [FDEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      fcount;

    // First source at/after ptr with requests left; descending scan so the nearest wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rem_req[(int'(ptr) + k) % N_SRC] != '0) begin
                pick_found = 1'b1;
                pick_idx   = SW'((int'(ptr) + k) % N_SRC);
            end
        end
    end

    // Requests count the word already in flight so the FIFO can never overflow.
    assign activate = (state == S_STREAM) && !act[g];
    assign can_req  = (state == S_STREAM) && act[g] && (rem_req[g] != '0) &&
                      (qcnt < QW'(QUANTUM)) && ((fcount + CW'(inflight)) < CW'(FDEPTH));
    assign reload   = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        src_enable  = '0;
        expect_mask = '0;
        cap_idx     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            src_enable[i]  = (can_req || activate) && (g == SW'(i));
            expect_mask[i] = inflight && (inflight_src == SW'(i));
            if (src_valid[i]) cap_idx = SW'(i);
        end
    end

    assign cap_vld    = |src_valid;
    assign cap_dat    = src_data[cap_idx*DW +: DW];
    assign stray_hit  = |(src_valid & ~expect_mask);
    assign flit_valid = (fcount != '0);
    assign pop        = flit_valid && flit_ready;
    assign push       = cap_vld && ((fcount != CW'(FDEPTH)) || pop);
    assign flit_out   = flit_valid ? mem[rd_ptr][DW-1:0] : '0;
    assign flit_src   = flit_valid ? mem[rd_ptr][SW+DW-1:DW] : '0;
    assign busy       = (state == S_ARB) || (state == S_STREAM) || (state == S_GAP) || (state == S_DRAIN);
    assign all_done   = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ARB;
            S_ARB:    state_nxt = pick_found ? S_STREAM : S_DRAIN;
            S_STREAM: if (can_req && ((qcnt == QW'(QUANTUM - 1)) || (rem_req[g] == RW'(1))))
                          state_nxt = S_GAP;
            S_GAP:    if (gcnt == GW'(GAP - 1)) state_nxt = S_ARB;
            S_DRAIN:  if ((fcount == '0) && !inflight) state_nxt = S_DONE;
            S_DONE:   if (start) state_nxt = S_ARB;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            g            <= '0;
            qcnt         <= '0;
            gcnt         <= '0;
            inflight     <= 1'b0;
            inflight_src <= '0;
            err_stray    <= 1'b0;
            act          <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                rem[i]     <= RW'(BURST_LEN);
                rem_req[i] <= RW'(BURST_LEN);
            end
        end else begin
            state    <= state_nxt;
            inflight <= can_req;
            gcnt     <= (state == S_GAP) ? gcnt + 1'b1 : '0;
            if (can_req) begin
                inflight_src <= g;
                rem_req[g]   <= rem_req[g] - 1'b1;
                qcnt         <= qcnt + 1'b1;
            end
            if (stray_hit) err_stray <= 1'b1;
            if ((state == S_ARB) && pick_found) begin
                g    <= pick_idx;
                qcnt <= '0;
            end
            if ((state == S_GAP) && (state_nxt == S_ARB))
                ptr <= (g == SW'(N_SRC - 1)) ? '0 : g + 1'b1;
            if (activate) act[g] <= 1'b1;
            for (int i = 0; i < N_SRC; i++)
                if (src_valid[i] && (rem[i] != '0)) rem[i] <= rem[i] - 1'b1;
            if (reload) begin
                ptr <= '0;
                act <= '0;
                for (int i = 0; i < N_SRC; i++) begin
                    rem[i]     <= RW'(BURST_LEN);
                    rem_req[i] <= RW'(BURST_LEN);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fcount <= fcount + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cap_idx, cap_dat};
    end
endmodule
